imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational immediate generator. It sits between instruction fetch/decode and the ALU/PC-update logic. Each accepted instruction passes through one register stage with a valid/ready handshake. The block decodes seven immediate formats, sign-extends to XLEN, and also produces a PC-relative target (pc + imm) for branches, JAL and AUIPC.

---
 rtl/imm_pkg.sv | 64 ++++++
 rtl/pipe_skid_reg.sv | 107 ++++++++++
 rtl/imm_gen_pipe.sv | 74 +++++++
 tb/tb_imm_gen_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared types and helpers for the pipelined immediate generator.
//   imm_sel_e      : immediate format select (3-bit encoding on in_sel).
//   imm_payload_t  : one output beat {imm, target, tag, sel_err}, laid out at
//                    the widest supported configuration (XLEN 64, tag 16 bits).
//                    Narrower instances carry the low bits and truncate at
//                    the ports; the unused upper flops have no loads.
//   shamt_width()  : shift-amount width for a given XLEN.
//   imm_decode()   : raw instruction + select -> immediate, extended to 64.
// ---------------------------------------------------------------------------
package imm_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 16;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_SH   = 3'b110,
    IMM_RSVD = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    logic [XLEN_MAX-1:0]  target;
    logic [TAG_W_MAX-1:0] tag;
    logic                 sel_err;
  } imm_payload_t;

  // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
  function automatic int shamt_width(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

  // The result is sign/zero-extended to 64 bits. Truncating it to 32 bits
  // gives exactly the RV32 immediate, since sign extension always starts
  // from instr[31] and the zero-extended formats fit in the low bits.
  function automatic logic [XLEN_MAX-1:0] imm_decode(input logic [31:0] instr,
                                                     input imm_sel_e    sel,
                                                     input int          shamt_w);
    logic [XLEN_MAX-1:0] imm;
    imm = '0;
    case (sel)
      IMM_I:  imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:  imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
      IMM_U:  imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:  imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
      IMM_Z:  imm = {59'b0, instr[19:15]};
      IMM_SH: imm = (shamt_w == 6) ? {58'b0, instr[25:20]}
                                   : {59'b0, instr[24:20]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Generic valid/ready register stage, latency 1, full throughput.
// Build option: IMM_GEN_SKID_EN
//   undefined : single output register, in_ready = !out_valid || out_ready.
//   defined   : output register plus a skid register; in_ready comes only
//               from the skid-occupancy flop (and rst), so out_ready has no
//               combinational path to in_ready.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake
//   in_data  [W-1:0]     : upstream payload
//   out_valid/out_ready  : downstream handshake
//   out_data [W-1:0]     : downstream payload, held stable while stalled
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_d, out_valid_q;
  logic [W-1:0] out_data_d,  out_data_q;

`ifdef IMM_GEN_SKID_EN

  logic         skid_valid_d, skid_valid_q;
  logic [W-1:0] skid_data_d,  skid_data_q;

  assign in_ready = !rst && !skid_valid_q;

  // The skid only fills when the output is stalled, and while it is full
  // in_ready is low, so the skid always holds the beat behind the output.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (out_ready) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || out_ready) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        out_data_d = in_data;
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`else

  assign in_ready = !rst && (!out_valid_q || out_ready);

  // A new accept replaces a beat draining this cycle, so there is no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator: decodes one of seven immediate formats,
// extends it to XLEN and forms pc + imm, then registers the result behind a
// valid/ready stage (latency 1).
// Build option: IMM_GEN_SKID_EN adds a skid entry to the register stage
// (see pipe_skid_reg); ordering and values are identical in both builds.
// Parameters: XLEN (32 or 64), TAG_W (1..16).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : upstream handshake
//   in_instr[31:0], in_sel   : instruction word, format select (imm_sel_e)
//   in_pc[XLEN-1:0], in_tag  : instruction PC, opaque sideband tag
//   out_valid/out_ready      : downstream handshake
//   out_imm, out_target      : extended immediate, pc + imm (mod 2^XLEN)
//   out_tag, out_sel_err     : passed-through tag, reserved-select flag
// ---------------------------------------------------------------------------
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sel_err
);

  localparam int SHAMT_W = shamt_width(XLEN);

  imm_payload_t        pay_d, pay_q;
  logic [XLEN_MAX-1:0] imm_full;

  // The target is formed at full width; its low XLEN bits equal the
  // XLEN-bit sum with the carry discarded.
  always_comb begin
    imm_full      = imm_decode(in_instr, imm_sel_e'(in_sel), SHAMT_W);
    pay_d         = '0;
    pay_d.imm     = imm_full;
    pay_d.target  = XLEN_MAX'(in_pc) + imm_full;
    pay_d.tag     = TAG_W_MAX'(in_tag);
    pay_d.sel_err = (imm_sel_e'(in_sel) == IMM_RSVD);
  end

  pipe_skid_reg #(
    .W($bits(imm_payload_t))
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_q)
  );

  assign out_imm     = XLEN'(pay_q.imm);
  assign out_target  = XLEN'(pay_q.target);
  assign out_tag     = TAG_W'(pay_q.tag);
  assign out_sel_err = pay_q.sel_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives an XLEN=32 and an XLEN=64 instance of imm_gen_pipe with the same
// stimulus and compares their outputs against hand-computed values.
// Honours IMM_GEN_SKID_EN for the in_ready expectations while stalled.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  sel;
  logic [63:0] pc;
  logic [3:0]  tag;
  logic        out_ready;

  logic        in_ready_32, out_valid_32, out_err_32;
  logic [31:0] out_imm_32, out_tgt_32;
  logic [3:0]  out_tag_32;
  logic        in_ready_64, out_valid_64, out_err_64;
  logic [63:0] out_imm_64, out_tgt_64;
  logic [3:0]  out_tag_64;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
    .in_instr(instr), .in_sel(sel), .in_pc(pc[31:0]), .in_tag(tag),
    .out_valid(out_valid_32), .out_ready(out_ready), .out_imm(out_imm_32),
    .out_target(out_tgt_32), .out_tag(out_tag_32), .out_sel_err(out_err_32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
    .in_instr(instr), .in_sel(sel), .in_pc(pc), .in_tag(tag),
    .out_valid(out_valid_64), .out_ready(out_ready), .out_imm(out_imm_64),
    .out_target(out_tgt_64), .out_tag(out_tag_64), .out_sel_err(out_err_64)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
  } vec_t;

  // Presents one beat for a single cycle; returns at the following negedge,
  // when the accepted beat is on the outputs (out_ready assumed high).
  task automatic apply_stimulus(input logic [31:0] i_instr, input logic [2:0] i_sel,
                                input logic [63:0] i_pc, input logic [3:0] i_tag);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = i_instr;
    sel      = i_sel;
    pc       = i_pc;
    tag      = i_tag;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    sel       = '0;
    pc        = '0;
    tag       = '0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (out_valid_32 !== 1'b0 || out_valid_64 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid got %b/%b want 0/0", out_valid_32, out_valid_64);
    end
    tests_run++;
    if (in_ready_32 !== 1'b0 || in_ready_64 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready_low got %b/%b want 0/0", in_ready_32, in_ready_64);
    end
    tests_run++;
    if ({out_imm_32, out_tgt_32, out_tag_32, out_err_32} !== '0 ||
        {out_imm_64, out_tgt_64, out_tag_64, out_err_64} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data got imm32=%h tgt32=%h tag=%h err=%b imm64=%h want all 0",
               out_imm_32, out_tgt_32, out_tag_32, out_err_32, out_imm_64);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready_32 !== 1'b1 || in_ready_64 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_in_ready got %b/%b want 1/1", in_ready_32, in_ready_64);
    end
  endtask

  task automatic test_formats;
    vec_t vecs[$];
    vecs.push_back('{"I_neg1", 32'hFFF00093, 3'b000, 64'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF});
    vecs.push_back('{"B_beq_m4", 32'hFE000EE3, 3'b010, 64'h100,
                     32'hFFFFFFFC, 32'h000000FC, 64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC});
    vecs.push_back('{"J_plus8", 32'h0080006F, 3'b100, 64'h100,
                     32'h00000008, 32'h00000108, 64'h8, 64'h108});
    vecs.push_back('{"S_m4", 32'hFE000E23, 3'b001, 64'h200,
                     32'hFFFFFFFC, 32'h000001FC, 64'hFFFFFFFFFFFFFFFC, 64'h1FC});
    vecs.push_back('{"U_neg", 32'h800000B7, 3'b011, 64'h0,
                     32'h80000000, 32'h80000000, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000});
    vecs.push_back('{"U_pos", 32'h12345037, 3'b011, 64'h1000,
                     32'h12345000, 32'h12346000, 64'h12345000, 64'h12346000});
    vecs.push_back('{"Z_uimm", 32'h000F8073, 3'b101, 64'h0,
                     32'h0000001F, 32'h0000001F, 64'h1F, 64'h1F});
    vecs.push_back('{"SH_shamt", 32'h03F01013, 3'b110, 64'h0,
                     32'h0000001F, 32'h0000001F, 64'h3F, 64'h3F});
    vecs.push_back('{"I_wrap", 32'h02000093, 3'b000, 64'hFFFFFFFFFFFFFFF0,
                     32'h00000020, 32'h00000010, 64'h20, 64'h10});
    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].instr, vecs[k].sel, vecs[k].pc, 4'(k));
      tests_run++;
      if (out_valid_32 !== 1'b1 || out_valid_64 !== 1'b1 ||
          out_tag_32 !== 4'(k) || out_tag_64 !== 4'(k) ||
          out_err_32 !== 1'b0 || out_err_64 !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s_ctrl got v=%b/%b tag=%h/%h err=%b/%b want v=1 tag=%h err=0",
                 vecs[k].name, out_valid_32, out_valid_64, out_tag_32, out_tag_64,
                 out_err_32, out_err_64, 4'(k));
      end
      tests_run++;
      if (out_imm_32 !== vecs[k].imm32 || out_tgt_32 !== vecs[k].tgt32) begin
        tests_failed++;
        $display("[TB] FAIL %s_x32 got imm=%h tgt=%h want imm=%h tgt=%h",
                 vecs[k].name, out_imm_32, out_tgt_32, vecs[k].imm32, vecs[k].tgt32);
      end
      tests_run++;
      if (out_imm_64 !== vecs[k].imm64 || out_tgt_64 !== vecs[k].tgt64) begin
        tests_failed++;
        $display("[TB] FAIL %s_x64 got imm=%h tgt=%h want imm=%h tgt=%h",
                 vecs[k].name, out_imm_64, out_tgt_64, vecs[k].imm64, vecs[k].tgt64);
      end
    end
  endtask

  task automatic test_sel_err;
    apply_stimulus(32'hFFFFFFFF, 3'b111, 64'h40, 4'hA);
    tests_run++;
    if (out_valid_32 !== 1'b1 || out_err_32 !== 1'b1 || out_imm_32 !== 32'h0 ||
        out_tgt_32 !== 32'h40 || out_tag_32 !== 4'hA) begin
      tests_failed++;
      $display("[TB] FAIL rsvd_x32 got v=%b err=%b imm=%h tgt=%h tag=%h want 1 1 0 40 a",
               out_valid_32, out_err_32, out_imm_32, out_tgt_32, out_tag_32);
    end
    tests_run++;
    if (out_err_64 !== 1'b1 || out_imm_64 !== 64'h0 || out_tgt_64 !== 64'h40) begin
      tests_failed++;
      $display("[TB] FAIL rsvd_x64 got err=%b imm=%h tgt=%h want 1 0 40",
               out_err_64, out_imm_64, out_tgt_64);
    end
    apply_stimulus(32'h00500093, 3'b000, 64'h40, 4'hB);
    tests_run++;
    if (out_err_32 !== 1'b0 || out_imm_32 !== 32'h5 || out_tgt_32 !== 32'h45 ||
        out_err_64 !== 1'b0 || out_imm_64 !== 64'h5) begin
      tests_failed++;
      $display("[TB] FAIL rsvd_then_I got err=%b/%b imm=%h/%h tgt=%h want 0/0 5/5 45",
               out_err_32, out_err_64, out_imm_32, out_imm_64, out_tgt_32);
    end
  endtask

  // Streams four I-type beats (tag t, imm 0x10+t, pc 0x1000) while stalling
  // the output for stall_len cycles starting at cycle stall_start. Checks
  // order, values, head-of-line stability while stalled and in_ready.
  task automatic run_stream(input string name, input int stall_start, input int stall_len,
                            input int want_cycles);
    int next_in  = 0;
    int exp_tag  = 0;
    int cycles   = 0;
    logic exp_rdy;
    for (int c = 0; c < 40 && exp_tag < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= stall_start && c < stall_start + stall_len);
      in_valid  = (next_in < 4);
      instr     = {12'(16 + next_in), 20'h00093};
      sel       = 3'b000;
      pc        = 64'h1000;
      tag       = 4'(next_in);
      #1;
      if (out_valid_32 && !out_ready) begin
        tests_run++;
        if (out_tag_32 !== 4'(exp_tag) || out_imm_32 !== 32'(16 + exp_tag) ||
            out_tag_64 !== 4'(exp_tag)) begin
          tests_failed++;
          $display("[TB] FAIL %s_stall_hold c=%0d got tag=%h imm=%h want tag=%h imm=%h",
                   name, c, out_tag_32, out_imm_32, 4'(exp_tag), 32'(16 + exp_tag));
        end
        if (in_valid) begin
`ifdef IMM_GEN_SKID_EN
          exp_rdy = (c == stall_start);
`else
          exp_rdy = 1'b0;
`endif
          tests_run++;
          if (in_ready_32 !== exp_rdy) begin
            tests_failed++;
            $display("[TB] FAIL %s_stall_in_ready c=%0d got %b want %b",
                     name, c, in_ready_32, exp_rdy);
          end
`ifdef IMM_GEN_SKID_EN
          if (c == stall_start + 1) begin
            out_ready = 1'b1;
            #1;
            tests_run++;
            if (in_ready_32 !== 1'b0 || in_ready_64 !== 1'b0) begin
              tests_failed++;
              $display("[TB] FAIL %s_skid_no_comb_path got %b/%b want 0/0",
                       name, in_ready_32, in_ready_64);
            end
            out_ready = 1'b0;
            #1;
          end
`endif
        end
      end
      if (out_valid_32 && out_ready) begin
        tests_run++;
        if (out_tag_32 !== 4'(exp_tag) || out_tag_64 !== 4'(exp_tag) ||
            out_imm_32 !== 32'(16 + exp_tag) || out_tgt_32 !== 32'(32'h1010 + exp_tag) ||
            out_tgt_64 !== 64'(64'h1010 + exp_tag)) begin
          tests_failed++;
          $display("[TB] FAIL %s_pop c=%0d got tag=%h/%h imm=%h tgt=%h want tag=%h imm=%h tgt=%h",
                   name, c, out_tag_32, out_tag_64, out_imm_32, out_tgt_32,
                   4'(exp_tag), 32'(16 + exp_tag), 32'(32'h1010 + exp_tag));
        end
        exp_tag++;
      end
      if (in_valid && in_ready_32) next_in++;
      cycles = c + 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (exp_tag != 4) begin
      tests_failed++;
      $display("[TB] FAIL %s_all_beats got %0d want 4", name, exp_tag);
    end
    if (want_cycles > 0) begin
      tests_run++;
      if (cycles != want_cycles) begin
        tests_failed++;
        $display("[TB] FAIL %s_throughput got %0d cycles want %0d", name, cycles, want_cycles);
      end
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid_32 !== 1'b0 || out_valid_64 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_no_duplicate got out_valid=%b/%b want 0/0",
               name, out_valid_32, out_valid_64);
    end
  endtask

  task automatic test_back_to_back;
    run_stream("b2b", 0, 0, 5);
  endtask

  task automatic test_backpressure;
    run_stream("bp", 2, 3, 0);
  endtask

  task automatic test_reset_in_flight;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    instr    = 32'h00500093;
    sel      = 3'b000;
    pc       = 64'h0;
    tag      = 4'h5;
    @(negedge clk);
    tag   = 4'h6;
    instr = 32'h00600093;
    #1;
    tests_run++;
    if (out_valid_32 !== 1'b1 || out_tag_32 !== 4'h5) begin
      tests_failed++;
      $display("[TB] FAIL rif_loaded got v=%b tag=%h want 1 5", out_valid_32, out_tag_32);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid_32 !== 1'b0 || out_valid_64 !== 1'b0 || in_ready_32 !== 1'b0 ||
        out_imm_32 !== 32'h0 || out_tag_32 !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL rif_flushed got v=%b/%b rdy=%b imm=%h tag=%h want 0/0 0 0 0",
               out_valid_32, out_valid_64, in_ready_32, out_imm_32, out_tag_32);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready_32 !== 1'b1 || in_ready_64 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rif_ready_after got %b/%b want 1/1", in_ready_32, in_ready_64);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid_32 !== 1'b0 || out_valid_64 !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rif_no_stale c=%0d got %b/%b want 0/0", c, out_valid_32, out_valid_64);
      end
    end
  endtask

  initial begin
    test_reset;
    test_formats;
    test_sel_err;
    test_back_to_back;
    test_backpressure;
    test_reset_in_flight;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
